// File: rtl/shared_unit_scheduler_pkg.sv
// shared_unit_scheduler_pkg: width helpers shared by the scheduler, its tag line and its interface
package shared_unit_scheduler_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req < 2) ? 1 : clog2(num_req);
    endfunction

    function automatic int cnt_width(input int latency);
        return clog2(latency + 1);
    endfunction

endpackage

// File: rtl/shared_unit_scheduler_if.sv
// shared_unit_scheduler_if: requester/result handshake bundle around the shared unit
interface shared_unit_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4
);
    import shared_unit_scheduler_pkg::*;

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(LATENCY);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic               unit_en;
    logic [ID_W-1:0]    unit_sel;
    logic [NUM_REQ-1:0] res_valid;
    logic [NUM_REQ-1:0] res_ready;
    logic [ID_W-1:0]    res_sel;
    logic [CNT_W-1:0]   inflight;

    modport master (
        output req_valid, res_ready,
        input  req_ready, unit_en, unit_sel, res_valid, res_sel, inflight
    );

    modport slave (
        input  req_valid, res_ready,
        output req_ready, unit_en, unit_sel, res_valid, res_sel, inflight
    );

endinterface

// File: rtl/shared_unit_scheduler_tag_line.sv
// sched_tag_line: {valid, id} shift register that mirrors the shared unit's pipeline depth
module sched_tag_line #(
    parameter int LATENCY = 4,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_v,
    input  logic [ID_W-1:0] in_id,
    output logic            head_v,
    output logic [ID_W-1:0] head_id
);

    logic [LATENCY-1:0]           v_q, v_d;
    logic [LATENCY-1:0][ID_W-1:0] id_q, id_d;

    // shift every stage by one on enable, bubbles included
    always_comb begin
        v_d  = v_q;
        id_d = id_q;
        if (en) begin
            v_d[0]  = in_v;
            id_d[0] = in_id;
            for (int k = 1; k < LATENCY; k++) begin
                v_d[k]  = v_q[k-1];
                id_d[k] = id_q[k-1];
            end
        end
    end

    // stage registers; reset drops every in-flight tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            id_q <= '0;
        end else begin
            v_q  <= v_d;
            id_q <= id_d;
        end
    end

    assign head_v  = v_q[LATENCY-1];
    assign head_id = id_q[LATENCY-1];

endmodule

// File: rtl/shared_unit_scheduler.sv
// shared_unit_scheduler: round-robin sharing of one fixed-latency pipelined unit with result steering
module shared_unit_scheduler
    import shared_unit_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    shared_unit_scheduler_if.slave bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(LATENCY);

    logic            head_v;
    logic [ID_W-1:0] head_id;
    logic            advance;
    logic            found;
    logic [ID_W-1:0] g;
    logic            fire;
    logic            pop;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    sched_tag_line #(.LATENCY(LATENCY), .ID_W(ID_W)) u_tag_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .in_v    (fire),
        .in_id   (g),
        .head_v  (head_v),
        .head_id (head_id)
    );

    // round-robin pick: the lowest offset from rr_ptr wins, so scan offsets high to low
    always_comb begin
        found = 1'b0;
        g     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid[(int'(rr_ptr_q) + j) % NUM_REQ]) begin
                found = 1'b1;
                g     = ID_W'((int'(rr_ptr_q) + j) % NUM_REQ);
            end
        end
    end

    // handshake, pointer/counter next state and result demux
    always_comb begin
        advance       = !head_v || bus.res_ready[head_id];
        fire          = advance && found;
        pop           = head_v && advance;
        bus.unit_en   = advance;
        bus.unit_sel  = found ? g : sel_q;
        bus.req_ready = fire ? (NUM_REQ'(1) << g) : '0;
        bus.res_valid = head_v ? (NUM_REQ'(1) << head_id) : '0;
        bus.res_sel   = head_id;
        bus.inflight  = inflight_q;
        sel_d         = bus.unit_sel;
        rr_ptr_d      = fire ? ID_W'((int'(g) + 1) % NUM_REQ) : rr_ptr_q;
        inflight_d    = (fire && !pop) ? inflight_q + CNT_W'(1) :
                        (pop && !fire) ? inflight_q - CNT_W'(1) : inflight_q;
    end

    // arbitration pointer, held operand select and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_shared_unit_scheduler.sv
// tb_shared_unit_scheduler: directed checks of arbitration, latency, backpressure and reset
module tb_shared_unit_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;
    int   ids [4] = '{2, 3, 0, 1};

    always #5 clk = ~clk;

    shared_unit_scheduler_if #(.NUM_REQ(4), .LATENCY(4)) bus_a ();
    shared_unit_scheduler_if #(.NUM_REQ(4), .LATENCY(1)) bus_b ();

    shared_unit_scheduler #(.NUM_REQ(4), .LATENCY(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    shared_unit_scheduler #(.NUM_REQ(4), .LATENCY(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] oh(input int n);
        return 32'(1) << n;
    endfunction

    initial begin
        rst_n = 1'b0;
        bus_a.req_valid = '0;
        bus_a.res_ready = '1;
        bus_b.req_valid = '0;
        bus_b.res_ready = '1;
        #2;
        check("rst_res_valid", 32'(bus_a.res_valid), 0);
        check("rst_unit_en", 32'(bus_a.unit_en), 1);
        check("rst_res_sel", 32'(bus_a.res_sel), 0);
        check("rst_inflight", 32'(bus_a.inflight), 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // single requester: one fire per cycle, inflight saturates at LATENCY
        bus_a.req_valid = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            #1;
            check("t1_req_ready", 32'(bus_a.req_ready), 1);
            check("t1_inflight", 32'(bus_a.inflight), (c < 4) ? c : 4);
            check("t1_res_valid", 32'(bus_a.res_valid), (c >= 4) ? 1 : 0);
            cyc();
        end
        bus_a.req_valid = '0;
        for (int d = 0; d < 4; d++) begin
            #1;
            check("t1_drain_valid", 32'(bus_a.res_valid), 1);
            check("t1_drain_inflight", 32'(bus_a.inflight), 4 - d);
            cyc();
        end
        check("t1_empty_valid", 32'(bus_a.res_valid), 0);
        check("t1_empty_inflight", 32'(bus_a.inflight), 0);

        // all requesting after a reset: grants 0,1,2,3,0,... and results in the same order
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus_a.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t2_unit_sel", 32'(bus_a.unit_sel), c % 4);
            check("t2_req_ready", 32'(bus_a.req_ready), oh(c % 4));
            check("t2_res_valid", 32'(bus_a.res_valid), (c >= 4) ? oh((c - 4) % 4) : 0);
            if (c >= 4) check("t2_res_sel", 32'(bus_a.res_sel), (c - 4) % 4);
            cyc();
        end
        bus_a.req_valid = '0;
        for (int d = 0; d < 4; d++) begin
            #1;
            check("t2_drain_valid", 32'(bus_a.res_valid), oh(d));
            check("t2_drain_inflight", 32'(bus_a.inflight), 4 - d);
            cyc();
        end
        check("t2_empty", 32'(bus_a.res_valid), 0);

        // backpressure on requester 2 for three cycles
        bus_a.req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t3_fill_sel", 32'(bus_a.unit_sel), c % 4);
            cyc();
        end
        bus_a.res_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_stall_en", 32'(bus_a.unit_en), 0);
            check("t3_stall_ready", 32'(bus_a.req_ready), 0);
            check("t3_stall_valid", 32'(bus_a.res_valid), 4'b0100);
            check("t3_stall_inflight", 32'(bus_a.inflight), 4);
            check("t3_stall_sel", 32'(bus_a.unit_sel), 2);
            cyc();
        end
        bus_a.res_ready = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t3_resume_valid", 32'(bus_a.res_valid), oh(ids[c]));
            check("t3_resume_ready", 32'(bus_a.req_ready), oh(ids[c]));
            cyc();
        end
        bus_a.req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t3_drain_valid", 32'(bus_a.res_valid), oh(ids[c]));
            cyc();
        end
        check("t3_empty_valid", 32'(bus_a.res_valid), 0);
        check("t3_empty_inflight", 32'(bus_a.inflight), 0);

        // sparse: requester 3 fires once, rr_ptr is 2 here
        bus_a.req_valid = 4'b1000;
        #1;
        check("t4_req_ready", 32'(bus_a.req_ready), 4'b1000);
        cyc();
        bus_a.req_valid = '0;
        for (int c = 1; c < 6; c++) begin
            #1;
            check("t4_res_valid", 32'(bus_a.res_valid), (c == 4) ? 32'h8 : 0);
            check("t4_inflight", 32'(bus_a.inflight), (c < 5) ? 1 : 0);
            if (c == 4) check("t4_res_sel", 32'(bus_a.res_sel), 3);
            cyc();
        end

        // reset mid-flight with three tags in the line
        bus_a.req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) cyc();
        bus_a.req_valid = '0;
        cyc();
        #1;
        check("t5_pre_valid", 32'(bus_a.res_valid), 1);
        check("t5_pre_inflight", 32'(bus_a.inflight), 3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus_a.res_valid), 0);
        check("t5_rst_inflight", 32'(bus_a.inflight), 0);
        check("t5_rst_en", 32'(bus_a.unit_en), 1);
        rst_n = 1'b1;
        bus_a.req_valid = 4'b1111;
        #1;
        check("t5_first_sel", 32'(bus_a.unit_sel), 0);
        check("t5_first_ready", 32'(bus_a.req_ready), 1);
        cyc();
        bus_a.req_valid = '0;
        for (int c = 0; c < 5; c++) cyc();
        check("t5_empty", 32'(bus_a.inflight), 0);

        // LATENCY=1: fire and pop every cycle, stalled head blocks new fires
        bus_b.req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t6_sel", 32'(bus_b.unit_sel), c % 4);
            check("t6_inflight", 32'(bus_b.inflight), (c == 0) ? 0 : 1);
            check("t6_res_valid", 32'(bus_b.res_valid), (c == 0) ? 0 : oh((c - 1) % 4));
            cyc();
        end
        bus_b.res_ready = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t6_stall_ready", 32'(bus_b.req_ready), 0);
            check("t6_stall_en", 32'(bus_b.unit_en), 0);
            check("t6_stall_valid", 32'(bus_b.res_valid), 4'b0010);
            check("t6_stall_inflight", 32'(bus_b.inflight), 1);
            cyc();
        end
        bus_b.res_ready = 4'b1111;
        #1;
        check("t6_resume_valid", 32'(bus_b.res_valid), 4'b0010);
        check("t6_resume_ready", 32'(bus_b.req_ready), 4'b0100);
        cyc();
        #1;
        check("t6_next_valid", 32'(bus_b.res_valid), 4'b0100);
        check("t6_next_inflight", 32'(bus_b.inflight), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shared_unit_scheduler.md
# shared_unit_scheduler

Round-robin scheduler that shares one pipelined functional unit of fixed latency among NUM_REQ requesters in an elastic dataflow circuit. It grants at most one request per cycle and drives the unit's pipeline enable and operand-select. It tracks each in-flight operation's valid bit and requester ID through a tag pipeline matched to the unit's depth, then steers each result back to its owner. The whole pipeline stalls while the result at the head is not accepted.

## Interface
- NUM_REQ, 4: number of requesters sharing the unit; ≥2.
- LATENCY, 4: pipeline depth of the shared unit in cycles; ≥1.
- ID_W, derived = clog2(NUM_REQ): requester-ID width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  operand valid per requester.
- req_ready  out  NUM_REQ  operand accepted per requester.
- unit_en  out  1  pipeline enable of the shared unit (advance).
- unit_sel  out  ID_W  operand-mux select = granted requester ID.
- res_valid  out  NUM_REQ  result valid, one-hot on owner or all-zero.
- res_ready  in  NUM_REQ  result consumer ready per requester.
- res_sel  out  ID_W  result-demux select = ID at head stage.
- inflight  out  clog2(LATENCY+1)  number of valid stages in the tag pipeline.

## Operation
- Tag pipeline: LATENCY stages, each holding {v, id}; stage 0 is the entry, stage LATENCY-1 is the head.
- advance = !head.v || res_ready[head.id]; unit_en = advance.
- Arbitration is combinational and round-robin: scan req_valid from rr_ptr upward modulo NUM_REQ; the first set bit is the grant g. No request means no grant, and unit_sel holds its last value.
- req_ready[i] = advance && grant present && g==i. The handshake fires on req_valid[i] && req_ready[i].
- On an edge with advance, all stages shift by one: stage0 ← {fire, g}, stage k ← stage k-1. A bubble (v=0) enters stage 0 when nothing fires. Bubbles are not collapsed.
- On an edge without advance, all stages, rr_ptr and inflight hold.
- rr_ptr ← (g+1) mod NUM_REQ on each fire; it is unchanged otherwise.
- res_valid[i] = head.v && head.id==i. res_sel = head.id.
- inflight counter:
  - +1 on fire without head pop.
  - −1 on head pop (head.v && advance) without fire.
  - unchanged when both or neither occur.
  - Never exceeds LATENCY.
- Outputs never depend combinationally on res_ready except through advance. req_valid never feeds res_valid combinationally.

## Timing
- Reset (asynchronous assert, synchronous deassert at the user's discretion):
  - All stage v=0 and id=0; rr_ptr=0; inflight=0.
  - Outputs during reset: res_valid=0, unit_en=1, res_sel=0.
- Latency: a request fired in cycle t shows res_valid in cycle t+LATENCY when there are no stalls. Each stall cycle adds one.
- Throughput: one grant per cycle when there is no backpressure.
- Simultaneous pop and fire in the same cycle: both happen and inflight is unchanged.
- Head stalled: req_ready is all-zero, and no operand is consumed until the head is accepted.
- Reset mid-operation drops all in-flight tags. Results still in the unit become invisible because their v bits are cleared.
- With LATENCY=1 the head is stage 0. A stalled head must still block new fires.

## Structure
- Shared package/header holds:
  - the clog2 constant function;
  - the ID_W and inflight-width derivations.
- Sub-module sched_tag_line holds the {v, id} shift register with enable, async active-low clear, and parameters LATENCY and ID_W.
- The top module holds:
  - the round-robin arbiter;
  - rr_ptr;
  - the inflight counter;
  - the demux logic.

## Test plan
- Single requester: NUM_REQ=4, LATENCY=4, req_valid=0001 held, res_ready=1111. Expect one fire per cycle, res_valid=0001 from cycle 4 after the first fire, and inflight saturating at 4.
- All requesting: req_valid=1111 continuously. Grants go 0,1,2,3,0,…; res_valid follows the same order LATENCY cycles later; rr_ptr wraps from 3 to 0.
- Backpressure: head owned by requester 2 with res_ready[2]=0 for 3 cycles. Expect unit_en=0, req_ready=0000 and all stages frozen for 3 cycles, then the pipeline resumes with no loss or duplication.
- Sparse traffic: requester 3 fires once, then idle. Expect bubbles in the stages, res_valid=1000 exactly one cycle, and inflight going 1 then back to 0 on the pop.
- Reset mid-flight: assert rst with inflight=3. Expect res_valid=0 and inflight=0 immediately (asynchronous), and after release the first grant goes to requester 0.
- LATENCY=1 corner: simultaneous fire and head pop every cycle, inflight stays at 1. A stalled head blocks req_ready.
